// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU controller: opcodes, ALU
// operation encodings, FSM states and the bundle of registered control lines.
package cpu_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b00001;
  localparam logic [4:0] OP_SW    = 5'b00010;
  localparam logic [4:0] OP_BEQ   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00100;
  localparam logic [4:0] OP_J     = 5'b00101;

  // FUNCT hands the operation over to the ALU decoder, which reads the funct field.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  // Control lines that depend only on the state. They are registered.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       illegal;
  } ctrl_t;

  // The reset value is the FETCH setting with the memory request held off.
  localparam ctrl_t CTRL_RESET = '{
    mem_req:  1'b0, memwrite: 1'b0, iord:    1'b0, alusrca:  1'b0,
    alusrcb:  2'b01, aluop:   ALU_ADD, pcsrc: 2'b00, regdst:  1'b0,
    regwrite: 1'b0, memtoreg: 1'b0, illegal: 1'b0
  };

  // Moore decode of the control lines for a given state. Any line not set is 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_req = 1'b1; c.alusrcb = 2'b01; c.aluop = ALU_ADD; end
      DECODE: begin c.alusrcb = 2'b11; c.aluop = ALU_ADD; end
      MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALU_ADD; end
      MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:  begin c.mem_req = 1'b1; c.memwrite = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.alusrcb = 2'b00; c.aluop = ALU_FUNCT; end
      ALUWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BRANCH: begin c.alusrca = 1'b1; c.aluop = ALU_SUB; c.pcsrc = 2'b01; end
      ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALU_ADD; end
      ADDIWB: begin c.regwrite = 1'b1; end
      JUMP:   begin c.pcsrc = 2'b10; end
      TRAP:   begin c.illegal = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic restart,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == LAST);

  // Wait counter: cleared on every state change, saturates at the last wait cycle.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block evaluation order.
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (waiting && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main controller: Moore FSM sequencing fetch, decode and the
// per-opcode execute steps, with a memory wait timeout that raises buserr.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluop,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       illegal,
  output logic       buserr
);

  state_t state, next_state;
  ctrl_t  ctrl_q;
  logic   ack, waiting, expired, timeout, restart;

  // mem_ready only counts while a request is actually on the bus, so it is
  // ignored in every state that does not drive mem_req.
  assign ack     = ctrl_q.mem_req & mem_ready;
  assign waiting = ctrl_q.mem_req & ~mem_ready;
  assign timeout = waiting & expired;
  // A timed-out FETCH returns to FETCH, so the timeout itself must also clear the counter.
  assign restart = (next_state != state) | timeout;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .restart (restart),
    .expired (expired)
  );

  // Next-state selection; a completed access wins over a timeout in the same cycle.
  always_comb begin
    // NOTE: defaulting next_state before the case keeps this block free of latches.
    next_state = state;
    case (state)
      FETCH: begin
        if (ack)          next_state = DECODE;
        else if (timeout) next_state = FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (ack)          next_state = MEMWB;
        else if (timeout) next_state = FETCH;
      end
      MEMWR:  if (ack || timeout) next_state = FETCH;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // State register plus the registered Moore control lines for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      ctrl_q <= CTRL_RESET;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
    end
  end

  // Strobes that must react to mem_ready or zero within the current cycle.
  assign irwrite = (state == FETCH) & ack;
  assign pcen    = irwrite | ((state == BRANCH) & zero) | (state == JUMP);
  assign buserr  = timeout;

  assign mem_req  = ctrl_q.mem_req;
  assign memwrite = ctrl_q.memwrite;
  assign iord     = ctrl_q.iord;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign aluop    = ctrl_q.aluop;
  assign pcsrc    = ctrl_q.pcsrc;
  assign regdst   = ctrl_q.regdst;
  assign regwrite = ctrl_q.regwrite;
  assign memtoreg = ctrl_q.memtoreg;
  assign illegal  = ctrl_q.illegal;

endmodule
